// File: rtl/key_event_debouncer.sv
// key_event_debouncer: tick-sampled multi-bit key debouncer feeding a valid/ready event FIFO.
// Define KEY_AUTOREPEAT_EN to build typematic auto-repeat; otherwise evtRepeat is tied to 0.
module key_event_debouncer #(
  parameter int WIDTH        = 8,
  parameter int CLKDIV       = 1000,
  parameter int STEADY       = 7,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic [WIDTH-1:0]              keyValues,
  input  logic                          evtReady,
  output logic                          evtValid,
  output logic [WIDTH-1:0]              evtData,
  output logic                          evtRepeat,
  output logic [WIDTH-1:0]              stableByte,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          overflow
);
  localparam int DW = $clog2(CLKDIV);
  localparam int SW = $clog2(STEADY + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  if (CLKDIV < 2 || STEADY < 1 || STEADY > 255 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("key_event_debouncer: illegal parameter set");
  end

  logic [DW-1:0]    div_q, div_d;
  logic [WIDTH-1:0] testing_q, testing_d, stable_q, stable_d;
  logic [SW-1:0]    steady_q, steady_d;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             tick, accept, push, pop, full, wr_en;
  logic [EW-1:0]    push_data, head;

  always_comb begin
    tick = div_q == DW'(CLKDIV - 1);
    div_d = tick ? '0 : div_q + 1'b1;
    testing_d = (tick && keyValues != testing_q) ? keyValues : testing_q;
    steady_d = !tick ? steady_q :
               keyValues != testing_q ? '0 :
               steady_q == SW'(STEADY) ? steady_q : steady_q + 1'b1;
    accept = steady_q == SW'(STEADY) && testing_q != stable_q;
    stable_d = accept ? testing_q : stable_q;
  end

`ifdef KEY_AUTOREPEAT_EN
  logic [RW-1:0] rep_q, rep_d, rep_next, rep_target;
  logic          rep_armed_q, rep_armed_d, rep_fire;

  // First repeat waits REPEAT_DELAY ticks, later ones REPEAT_RATE; an accept always pre-empts a repeat.
  always_comb begin
    rep_target = rep_armed_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
    rep_next = rep_q + 1'b1;
    rep_fire = tick && !accept && stable_q != '0 && rep_next == rep_target;
    rep_d = (accept || stable_q == '0 || rep_fire) ? '0 : tick ? rep_next : rep_q;
    rep_armed_d = (accept || stable_q == '0) ? 1'b0 : rep_fire ? 1'b1 : rep_armed_q;
    push = accept || rep_fire;
    push_data = accept ? {1'b0, testing_q} : {1'b1, stable_q};
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rep_q <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  always_comb begin
    push = accept;
    push_data = testing_q;
  end
`endif

  // A full FIFO still takes a push when the head leaves on the same edge.
  always_comb begin
    full = cnt_q == CW'(FIFO_DEPTH);
    pop = cnt_q != '0 && evtReady;
    wr_en = push && (!full || pop);
    ovf_d = push && full && !pop;
    wr_d = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(wr_en) - CW'(pop);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q] = push_data;
    head = cnt_q == '0 ? '0 : mem_q[rd_q];
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      div_q <= '0;
      testing_q <= '0;
      steady_q <= '0;
      stable_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      div_q <= div_d;
      testing_q <= testing_d;
      steady_q <= steady_d;
      stable_q <= stable_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      mem_q <= mem_d;
    end
  end

  assign evtValid = cnt_q != '0;
  assign evtData = head[WIDTH-1:0];
  assign stableByte = stable_q;
  assign fifoCount = cnt_q;
  assign overflow = ovf_q;
`ifdef KEY_AUTOREPEAT_EN
  assign evtRepeat = head[WIDTH];
`else
  assign evtRepeat = 1'b0;
`endif
endmodule

// File: tb/tb_key_event_debouncer.sv
// tb_key_event_debouncer: scoreboard bench; the reference model decides acceptance from the
// history of tick samples and repeats from tick counts since the last accepted change.
module tb_key_event_debouncer;
  localparam int W = 8, CD = 4, ST = 3, FD = 4, RD = 5, RR = 2;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic [W-1:0] keyValues = '0;
  logic evtReady = 1'b0;
  logic evtValid, evtRepeat, overflow;
  logic [W-1:0] evtData, stableByte;
  logic [$clog2(FD):0] fifoCount;

  always #5 clk = ~clk;

  key_event_debouncer #(
    .WIDTH(W), .CLKDIV(CD), .STEADY(ST), .FIFO_DEPTH(FD), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .RST(RST), .keyValues(keyValues), .evtReady(evtReady), .evtValid(evtValid),
    .evtData(evtData), .evtRepeat(evtRepeat), .stableByte(stableByte), .fifoCount(fifoCount),
    .overflow(overflow)
  );

  int checks = 0, errors = 0;
  int ovf_seen = 0, rep_seen = 0;

  logic [W-1:0] hist[$];
  logic [W:0]   sb[$];
  logic [W-1:0] m_stable = '0;
  int  cyc = 0, m_cnt = 0, held = 0;
  bit  exp_ovf = 0, m_acc_next = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // A value is accepted once the last STEADY+1 tick samples agree and differ from the stable value.
  function automatic bit acc_cond();
    if (hist.size() < ST + 1) return 1'b0;
    foreach (hist[i]) if (hist[i] != hist[hist.size()-1]) return 1'b0;
    return hist[hist.size()-1] != m_stable;
  endfunction

  initial begin
    bit acc, tck, rpt, pop, push, drop;
    forever begin
      @(posedge clk or posedge RST);
      if (RST) begin
        cyc = 0; hist.delete(); hist.push_back('0); m_stable = '0;
        m_cnt = 0; held = 0; exp_ovf = 0; sb.delete(); m_acc_next = 0;
      end else begin
        acc = acc_cond();
        tck = (cyc % CD) == CD - 1;
        rpt = 0;
`ifdef KEY_AUTOREPEAT_EN
        if (!acc && tck && m_stable != 0) begin
          held++;
          rpt = (held == RD) || (held > RD && (held - RD) % RR == 0);
        end
`endif
        pop = m_cnt > 0 && evtReady;
        push = acc || rpt;
        drop = push && m_cnt == FD && !pop;
        exp_ovf = drop;
        if (push && !drop) sb.push_back(acc ? {1'b0, hist[$]} : {1'b1, m_stable});
        m_cnt = m_cnt + ((push && !drop) ? 1 : 0) - (pop ? 1 : 0);
        if (acc) begin m_stable = hist[$]; held = 0; end
        if (tck) begin
          hist.push_back(keyValues);
          if (hist.size() > ST + 1) void'(hist.pop_front());
        end
        cyc++;
        m_acc_next = acc_cond();
      end
    end
  end

  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (!RST) begin
        chk("fifoCount", fifoCount, m_cnt);
        chk("evtValid", evtValid, m_cnt != 0);
        chk("stableByte", stableByte, m_stable);
        chk("overflow", overflow, exp_ovf);
        if (overflow) ovf_seen++;
        if (evtValid && evtReady) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_event: got %0h expected none", {evtRepeat, evtData});
          end else begin
            e = sb.pop_front();
            chk("event", {evtRepeat, evtData}, e);
            if (evtRepeat) rep_seen++;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic settle(input logic [W-1:0] v);
    keyValues = v;
    step(20);
  endtask

  initial begin
    int k, o0, r0;
    step(3);
    RST = 1'b0;
    chk("count_after_por", fifoCount, 0);
    settle(8'h41);
    settle(8'h42);
    chk("two_queued", fifoCount, 2);
    keyValues = 8'h5A;
    step(2);
    #2 RST = 1'b1;
    #1 chk("async_reset_outputs", {evtValid, evtRepeat, overflow, evtData, stableByte, fifoCount}, 0);
    step(2);
    RST = 1'b0;
    chk("count_after_reset", fifoCount, 0);
    step(16);
    chk("stable_before_4_ticks", stableByte, 0);
    step(1);
    chk("stable_after_4_ticks", stableByte, 8'h5A);
    evtReady = 1'b1;
    step(4);
    settle(8'h00);
    evtReady = 1'b0;

    keyValues = 8'h41;
    k = 0;
    while (!evtValid && k < 20) begin step(1); k++; end
    chk("press_latency", (k <= 17) && evtValid, 1);
    chk("press_data", evtData, 8'h41);
    evtReady = 1'b1;
    step(1);
    evtReady = 1'b0;
    chk("valid_falls_after_pop", evtValid, 0);
    evtReady = 1'b1;
    settle(8'h00);

    o0 = ovf_seen;
    for (int i = 0; i < 10; i++) begin
      keyValues = (i % 2) ? 8'h00 : 8'h41;
      step(CD);
    end
    settle(8'h00);
    chk("bounce_no_overflow", ovf_seen - o0, 0);
    chk("bounce_stable", stableByte, 0);
    chk("bounce_no_events", fifoCount, 0);

    evtReady = 1'b0;
    o0 = ovf_seen;
    for (int v = 1; v <= 5; v++) settle(W'(v));
    chk("ovf_count_full", fifoCount, 4);
    chk("ovf_single_pulse", ovf_seen - o0, 1);
    chk("ovf_stable", stableByte, 8'h05);
    evtReady = 1'b1;
    step(8);
    evtReady = 1'b0;
    chk("drained", fifoCount, 0);

    for (int v = 1; v <= 4; v++) settle(W'(v));
    keyValues = 8'h06;
    k = 0;
    while (!m_acc_next && k < 40) begin step(1); k++; end
    chk("accept_reached", m_acc_next, 1);
    evtReady = 1'b1;
    step(1);
    evtReady = 1'b0;
    chk("pushpop_count", fifoCount, 4);
    chk("pushpop_no_ovf", overflow, 0);
    chk("pushpop_stable", stableByte, 8'h06);
    evtReady = 1'b1;
    step(8);

    r0 = rep_seen;
    keyValues = 8'h20;
    step(70);
    keyValues = 8'h00;
    step(40);
`ifdef KEY_AUTOREPEAT_EN
    chk("repeats_seen", (rep_seen - r0) >= 3, 1);
`else
    chk("no_repeats", rep_seen - r0, 0);
`endif
    chk("release_stable", stableByte, 0);

    for (int it = 0; it < 250; it++) begin
      k = $urandom_range(0, 3);
      keyValues = (k == 0) ? 8'h00 : (k == 1) ? 8'h20 : (k == 2) ? 8'h41 : W'($urandom);
      repeat ($urandom_range(1, 30)) begin
        evtReady = $urandom_range(0, 3) != 0;
        step(1);
      end
    end
    keyValues = 8'h00;
    evtReady = 1'b1;
    step(60);
    chk("scoreboard_empty", sb.size(), 0);
    chk("final_count", fifoCount, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
